// File: rtl/mul_arbiter_if.sv
// Handshake bundle shared by the requesters, the multiplier and mul_arbiter.
// slave = arbiter view, master = environment (requesters + multiplier) view.
interface mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
);
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_stb;
  logic [NUM_REQ-1:0]    req_ack;
  logic [31:0]           res_z;
  logic [NUM_REQ-1:0]    res_stb;
  logic [NUM_REQ-1:0]    res_ack;
  logic [31:0]           mul_a;
  logic                  mul_a_stb;
  logic                  mul_a_ack;
  logic [31:0]           mul_b;
  logic                  mul_b_stb;
  logic                  mul_b_ack;
  logic [31:0]           mul_z;
  logic                  mul_z_stb;
  logic                  mul_z_ack;
  logic [PTR_W-1:0]      grant;
  logic                  busy;

  modport slave (
    input  req_a, req_b, req_stb, res_ack, mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
    output req_ack, res_z, res_stb, mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack,
           grant, busy
  );

  modport master (
    output req_a, req_b, req_stb, res_ack, mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
    input  req_ack, res_z, res_stb, mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack,
           grant, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin scheduler sharing one multiplier among NUM_REQ requesters.
// Define MUL_ARB_PERF_EN to add the op_count / busy_cycles counters.
//
// state  | meaning
// IDLE   | waiting for any req_stb; picks next requester from ptr
// LATCH  | req_ack high, operand pair accepted on this edge
// SEND   | mul_a_stb / mul_b_stb high until each is acked
// WAIT_Z | mul_z_ack high, waiting for the product
// RETURN | res_stb[grant] high until res_ack[grant]
module mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  mul_arbiter_if.slave       bus
`ifdef MUL_ARB_PERF_EN
  ,
  output logic [31:0]        op_count,
  output logic [31:0]        busy_cycles
`endif
);

  localparam int SW = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, LATCH, SEND, WAIT_Z, RETURN} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] pick;
  logic             pick_valid;
  logic [SW-1:0]    scan;
  logic [31:0]      pick_a;
  logic [31:0]      pick_b;

  // Scan downwards so the candidate closest to ptr is the one that sticks.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    scan       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr} + SW'(k);
      if (scan >= SW'(NUM_REQ)) scan = scan - SW'(NUM_REQ);
      if (bus.req_stb[scan[PTR_W-1:0]]) begin
        pick_valid = 1'b1;
        pick       = scan[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == pick) begin
        pick_a = bus.req_a[32*k +: 32];
        pick_b = bus.req_b[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.grant     <= '0;
      bus.req_ack   <= '0;
      bus.res_stb   <= '0;
      bus.res_z     <= '0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.mul_a_stb <= 1'b0;
      bus.mul_b_stb <= 1'b0;
      bus.mul_z_ack <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.mul_a   <= pick_a;
            bus.mul_b   <= pick_b;
            bus.grant   <= pick;
            bus.req_ack <= NUM_REQ'(1) << pick;
            bus.busy    <= 1'b1;
            state       <= LATCH;
          end
        end
        LATCH: begin
          bus.req_ack   <= '0;
          bus.mul_a_stb <= 1'b1;
          bus.mul_b_stb <= 1'b1;
          state         <= SEND;
        end
        SEND: begin
          // a and b complete independently, possibly on the same edge
          if (bus.mul_a_ack) bus.mul_a_stb <= 1'b0;
          if (bus.mul_b_ack) bus.mul_b_stb <= 1'b0;
          if ((!bus.mul_a_stb || bus.mul_a_ack) && (!bus.mul_b_stb || bus.mul_b_ack)) begin
            bus.mul_z_ack <= 1'b1;
            state         <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (bus.mul_z_stb) begin
            bus.res_z     <= bus.mul_z;
            bus.mul_z_ack <= 1'b0;
            bus.res_stb   <= NUM_REQ'(1) << bus.grant;
            state         <= RETURN;
          end
        end
        RETURN: begin
          if (bus.res_ack[bus.grant]) begin
            bus.res_stb <= '0;
            ptr         <= (bus.grant == PTR_W'(NUM_REQ - 1)) ? '0 : bus.grant + 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count    <= '0;
      busy_cycles <= '0;
    end else begin
      if (bus.busy) busy_cycles <= busy_cycles + 32'd1;
      if (state == RETURN && bus.res_ack[bus.grant]) op_count <= op_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: stub multiplier with random handshake timing, directed
// vector table, hand-written corner sequences and random traffic vs a queue model.
module tb_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int PTR_W   = 2;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  bit   mock_hold;
  logic [31:0] mock_a, mock_b;
  logic [31:0] opa [NUM_REQ];
  logic [31:0] opb [NUM_REQ];

  mul_arbiter_if #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) bus ();

`ifdef MUL_ARB_PERF_EN
  logic [31:0] op_count, busy_cycles;
  int busy_cnt;
`endif

  mul_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MUL_ARB_PERF_EN
    ,
    .op_count(op_count),
    .busy_cycles(busy_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } vec_t;

  // Truncating single-precision multiply for normal operands (reference product).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], 8'(e), m};
  endfunction

  function automatic logic [31:0] rand_f();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(100, 150));
    return v;
  endfunction

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: bound expired, got no event, required one", name);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_res_z"}, bus.res_z, 0);
    chk({tag, "_mul_ab"}, {bus.mul_a, bus.mul_b}, 0);
    chk({tag, "_ctrl"}, {bus.req_ack, bus.res_stb, bus.mul_a_stb, bus.mul_b_stb,
                         bus.mul_z_ack, bus.grant, bus.busy}, 0);
  endtask

  task automatic raise(input int r, input logic [31:0] a, input logic [31:0] b);
    opa[r] = a;
    opb[r] = b;
    bus.req_a[32*r +: 32] = a;
    bus.req_b[32*r +: 32] = b;
    bus.req_stb[r] = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    bus.req_stb = '0;
    bus.res_ack = '0;
    mock_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int r, input string tag);
    int n;
    n = 0;
    while (bus.req_ack == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ack == '0) begin
      fail_to({tag, "_ack_timeout"});
      return;
    end
    chk({tag, "_req_ack"}, bus.req_ack, oh(r));
    chk({tag, "_grant"}, bus.grant, r);
    @(negedge clk);
    bus.req_stb[r] = 1'b0;
    chk({tag, "_ack_pulse"}, bus.req_ack, 0);
  endtask

  task automatic wait_res(input int r, input logic [31:0] exp_z, input int bp, input string tag);
    int n;
    bit stable;
    logic [31:0] z0;
    logic [NUM_REQ-1:0] s0;
    n = 0;
    stable = 1'b1;
    while (bus.res_stb == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.res_stb == '0) begin
      fail_to({tag, "_res_timeout"});
      return;
    end
    chk({tag, "_res_stb"}, bus.res_stb, oh(r));
    chk({tag, "_res_z"}, bus.res_z, exp_z);
    if (bp > 0) begin
      z0 = bus.res_z;
      s0 = bus.res_stb;
      bus.res_ack = ~oh(r);
      repeat (bp) begin
        @(negedge clk);
        if (bus.res_z !== z0 || bus.res_stb !== s0 || bus.req_ack !== '0) stable = 1'b0;
      end
      chk({tag, "_bp_hold"}, stable, 1);
    end
    bus.res_ack = oh(r);
    @(negedge clk);
    bus.res_ack = '0;
    chk({tag, "_res_done"}, bus.res_stb, 0);
    chk({tag, "_busy_low"}, bus.busy, 0);
  endtask

  // Model: one op at a time; grant = first pending requester from ptr_m, then ptr_m = grant+1.
  task automatic run_traffic(input int n_total);
    int ptr_m, cur, done, cyc, bp, e, idx;
    int rem [NUM_REQ];
    bit inflight [NUM_REQ];
    bit drop_next [NUM_REQ];
    bit res_acking, res_checked;
    logic [NUM_REQ-1:0] stb_seen;
    logic [31:0] exp_z;
    ptr_m = 0; cur = -1; done = 0; cyc = 0; bp = 0;
    res_acking = 1'b0; res_checked = 1'b0; exp_z = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = n_total / NUM_REQ;
      inflight[i] = 1'b0;
      drop_next[i] = 1'b0;
    end
    while (done < n_total && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      stb_seen = bus.req_stb;
      if (res_acking) begin
        bus.res_ack = '0;
        res_acking = 1'b0;
        chk("rnd_res_done", bus.res_stb, 0);
        if (cur >= 0) begin
          inflight[cur] = 1'b0;
          ptr_m = (cur + 1) % NUM_REQ;
        end
        cur = -1;
        done++;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (drop_next[i]) begin
          bus.req_stb[i] = 1'b0;
          drop_next[i] = 1'b0;
        end
      end
      if (bus.req_ack != '0) begin
        e = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (ptr_m + k) % NUM_REQ;
          if (e < 0 && stb_seen[idx]) e = idx;
        end
        if (e < 0) begin
          chk("rnd_spurious_ack", bus.req_ack, 0);
        end else begin
          chk("rnd_req_ack", bus.req_ack, oh(e));
          chk("rnd_grant", bus.grant, e);
          cur = e;
          drop_next[e] = 1'b1;
          exp_z = fmul(opa[e], opb[e]);
          bp = $urandom_range(0, 3);
        end
      end
      if (cur >= 0 && !res_acking && bus.res_stb != '0) begin
        if (!res_checked) begin
          chk("rnd_res_stb", bus.res_stb, oh(cur));
          chk("rnd_res_z", bus.res_z, exp_z);
          chk("rnd_mul_ab", {mock_a, mock_b}, {opa[cur], opb[cur]});
          res_checked = 1'b1;
        end
        if (bp == 0) begin
          bus.res_ack[cur] = 1'b1;
          res_acking = 1'b1;
          res_checked = 1'b0;
        end else begin
          bp--;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!inflight[i] && rem[i] > 0 && $urandom_range(0, 2) == 0) begin
          raise(i, rand_f(), rand_f());
          inflight[i] = 1'b1;
          rem[i]--;
        end
      end
    end
    if (done < n_total) fail_to("rnd_traffic_timeout");
  endtask

  // Stub multiplier: random per-operand ack timing, random result latency.
  initial begin
    bit got_a, got_b;
    int lat, n;
    bus.mul_a_ack = 1'b0;
    bus.mul_b_ack = 1'b0;
    bus.mul_z_stb = 1'b0;
    bus.mul_z = '0;
    mock_a = '0;
    mock_b = '0;
    forever begin
      got_a = 1'b0;
      got_b = 1'b0;
      while (!(got_a && got_b)) begin
        @(negedge clk);
        if (!rst) begin
          got_a = 1'b0;
          got_b = 1'b0;
          bus.mul_a_ack = 1'b0;
          bus.mul_b_ack = 1'b0;
        end else begin
          bus.mul_a_ack = bus.mul_a_stb && !got_a && ($urandom_range(0, 1) == 1);
          if (bus.mul_a_ack) begin
            mock_a = bus.mul_a;
            got_a = 1'b1;
          end
          bus.mul_b_ack = bus.mul_b_stb && !got_b && ($urandom_range(0, 1) == 1);
          if (bus.mul_b_ack) begin
            mock_b = bus.mul_b;
            got_b = 1'b1;
          end
        end
      end
      @(negedge clk);
      bus.mul_a_ack = 1'b0;
      bus.mul_b_ack = 1'b0;
      lat = $urandom_range(0, 3);
      while ((lat > 0 || mock_hold) && rst) begin
        @(negedge clk);
        if (lat > 0) lat--;
      end
      if (rst) begin
        bus.mul_z = fmul(mock_a, mock_b);
        bus.mul_z_stb = 1'b1;
        n = 0;
        while (bus.mul_z_ack !== 1'b1 && rst && n < 1000) begin
          @(negedge clk);
          n++;
        end
        if (rst) @(negedge clk);
        bus.mul_z_stb = 1'b0;
      end
    end
  end

`ifdef MUL_ARB_PERF_EN
  initial begin
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) busy_cnt = 0;
      else if (bus.busy) busy_cnt++;
    end
  end
`endif

  initial begin
    vec_t vecs [5];
    int   n;
    logic [31:0] fa [NUM_REQ];
    logic [31:0] fb [NUM_REQ];

    vecs[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000};
    vecs[1] = '{1, 32'h3FC00000, 32'hC0000000, 32'hC0400000};
    vecs[2] = '{2, 32'h40800000, 32'h3F000000, 32'h40000000};
    vecs[3] = '{3, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    vecs[4] = '{1, 32'hC0000000, 32'hC0000000, 32'h40800000};

    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    mock_hold = 1'b0;
    bus.req_stb = '0;
    bus.res_ack = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      raise(vecs[i].r, vecs[i].a, vecs[i].b);
      wait_ack(vecs[i].r, "vec");
      wait_res(vecs[i].r, vecs[i].z, 0, "vec");
    end

    // Simultaneous requests 0 and 2 from ptr=0
    apply_reset();
    raise(0, 32'h3FC00000, 32'hC0000000);
    raise(2, 32'h40800000, 32'h3F000000);
    wait_ack(0, "sim0");
    wait_res(0, 32'hC0400000, 0, "sim0");
    wait_ack(2, "sim2");
    wait_res(2, 32'h40000000, 0, "sim2");

    // All requesters continuously asserting
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      fa[i] = rand_f();
      fb[i] = rand_f();
      raise(i, fa[i], fb[i]);
    end
    for (int k = 0; k < 6; k++) begin
      wait_ack(k % NUM_REQ, "fair");
      wait_res(k % NUM_REQ, fmul(fa[k % NUM_REQ], fb[k % NUM_REQ]), 0, "fair");
      fa[k % NUM_REQ] = rand_f();
      fb[k % NUM_REQ] = rand_f();
      raise(k % NUM_REQ, fa[k % NUM_REQ], fb[k % NUM_REQ]);
    end

    // Result backpressure on requester 1 while requester 0 waits
    apply_reset();
    raise(1, 32'h40000000, 32'h40400000);
    wait_ack(1, "bp1");
    raise(0, 32'h3F800000, 32'h40800000);
    wait_res(1, 32'h40C00000, 20, "bp1");
    wait_ack(0, "bp0");
    wait_res(0, 32'h40800000, 0, "bp0");

    // Reset while waiting for the product; ptr is 1 here, so grant 0 proves ptr cleared
    mock_hold = 1'b1;
    raise(2, 32'h40000000, 32'h40000000);
    wait_ack(2, "mid");
    n = 0;
    while (bus.mul_z_ack !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.mul_z_ack !== 1'b1) fail_to("mid_waitz_timeout");
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    bus.req_stb = '0;
    bus.res_ack = '0;
    @(negedge clk);
    rst = 1'b1;
    mock_hold = 1'b0;
    @(negedge clk);
    raise(0, 32'h40400000, 32'h40400000);
    raise(1, 32'h3F000000, 32'h3F000000);
    wait_ack(0, "post_rst0");
    wait_res(0, 32'h41100000, 0, "post_rst0");
    wait_ack(1, "post_rst1");
    wait_res(1, 32'h3E800000, 0, "post_rst1");

    apply_reset();
    run_traffic(40);

`ifdef MUL_ARB_PERF_EN
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      raise(vecs[i].r, vecs[i].a, vecs[i].b);
      wait_ack(vecs[i].r, "perf");
      wait_res(vecs[i].r, vecs[i].z, 0, "perf");
    end
    chk("perf_op_count", op_count, 5);
    chk("perf_busy_cycles", busy_cycles, busy_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Round-robin scheduler that shares one single-precision `multiplier` instance among NUM_REQ requesters.
- Each requester presents an operand pair (a, b) on a stb/ack channel. The arbiter forwards the pair to the multiplier's input_a/input_b channels and collects output_z. It then returns the product on the requester's result channel.
- One operation in flight at a time.
- Sits between operand sources (file readers, compute nodes) and the multiplier.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- PTR_W, 2: width of grant/pointer index; must satisfy 2^PTR_W >= NUM_REQ.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_a  in  32*NUM_REQ  operand a per requester; slice i = bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand b per requester, same slicing.
- req_stb  in  NUM_REQ  operand pair valid per requester.
- req_ack  out  NUM_REQ  operand pair accepted, one-hot.
- res_z  out  32  product, shared by all requesters.
- res_stb  out  NUM_REQ  result valid for requester i, one-hot.
- res_ack  in  NUM_REQ  result taken by requester i.
- mul_a  out  32  to multiplier input_a.
- mul_a_stb  out  1  to multiplier input_a_stb.
- mul_a_ack  in  1  from multiplier input_a_ack.
- mul_b  out  32  to multiplier input_b.
- mul_b_stb  out  1  to multiplier input_b_stb.
- mul_b_ack  in  1  from multiplier input_b_ack.
- mul_z  in  32  from multiplier output_z.
- mul_z_stb  in  1  from multiplier output_z_stb.
- mul_z_ack  out  1  to multiplier output_z_ack.
- grant  out  PTR_W  index of requester currently being served.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Handshake rule: a transfer completes on the rising edge where stb && ack are both high. A source holds stb and data stable until that edge. All outputs are registered.
- Reset (rst=0, async) forces:
  - state=IDLE, ptr=0, grant=0;
  - all stb/ack outputs 0, busy=0;
  - res_z=0, mul_a=0, mul_b=0.
- Reset mid-operation abandons the operation without a result. The multiplier shares the same reset.
- FSM states: IDLE, LATCH, SEND, WAIT_Z, RETURN.
- IDLE:
  - If any req_stb is high, select the first requester i with req_stb[i]=1, scanning ptr, ptr+1, … mod NUM_REQ.
  - On that edge: capture req_a/req_b slice i into mul_a/mul_b, set grant=i, req_ack[i]=1, go to LATCH.
  - Otherwise stay.
- LATCH (1 cycle):
  - req_ack[grant]=1 here; the operand handshake completes on this edge.
  - Next: req_ack=0, mul_a_stb=1, mul_b_stb=1, go to SEND.
- SEND:
  - mul_a_stb drops on the edge its handshake completes; mul_b_stb likewise, independently. a and b may complete in either order or on the same edge.
  - Once both handshakes are done, go to WAIT_Z with mul_z_ack=1.
- WAIT_Z:
  - On mul_z_stb && mul_z_ack: capture mul_z into res_z, set mul_z_ack=0, res_stb[grant]=1, go to RETURN.
  - No timeout.
- RETURN:
  - Hold res_stb[grant] and res_z until res_ack[grant].
  - On handshake: res_stb=0, ptr=(grant+1) mod NUM_REQ, go to IDLE.
  - res_ack from non-granted requesters is ignored.
- Minimum latency, req_stb high (in IDLE) to res_stb high: 3 cycles + multiplier latency.
- Fairness:
  - A requester holding req_stb is served within NUM_REQ-1 other operations.
  - Simultaneous requests are resolved by rotating priority only; a requester just served has lowest priority next.
- Arithmetic: none. Operands and results pass through bit-exact.
- Protocol violations, with no recovery required:
  - req_stb dropped before req_ack;
  - new req_stb from the granted requester before res_ack.

Optional Feature:
- Macro: MUL_ARB_PERF_EN.
- Defined: adds output ports op_count[31:0] and busy_cycles[31:0], both reset to 0.
  - op_count increments on each completed RETURN handshake.
  - busy_cycles increments every cycle busy=1.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single request: req 0 sends a=0x40000000 (2.0), b=0x40400000 (3.0) -> res_stb[0] with res_z=0x40C00000 (6.0); req_ack[0] pulses exactly 1 cycle; busy low afterwards.
- Simultaneous: reqs 0 and 2 assert together, req 0 a=0x3FC00000, b=0xC0000000; req 2 a=0x40800000, b=0x3F000000 -> req 0 served first with 0xC0400000 (-3.0), then req 2 with 0x40000000 (2.0); grant sequence 0, 2.
- Fairness: all 4 requesters continuously asserting -> grant order 0,1,2,3,0,1 over 6 operations, with no requester skipped.
- Result backpressure: hold res_ack[1]=0 for 20 cycles after res_stb[1] -> res_stb[1] and res_z held stable; no new req_ack issued; completes on the first res_ack[1]=1 edge.
- Reset mid-op: assert rst=0 while in WAIT_Z -> all outputs 0 immediately (async); after release the first request is granted from ptr=0.
- MUL_ARB_PERF_EN: run 5 operations -> op_count=5; busy_cycles equals the measured total cycles busy=1.
